// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

  // Digit counter width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational compare of one D-bit digit: equality and unsigned greater-than.
module digit_compare #(
  parameter int unsigned D = 2
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  output logic         deq,
  output logic         dgt
);

  always_comb begin
    deq = (x == y);
    dgt = (x > y);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator with start/done handshake and
// early termination on the first differing digit.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int unsigned NDIG = W / D;
  localparam int unsigned KW   = cnt_width(NDIG);
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  cmp_state_t    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [KW-1:0] k_q, k_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic [W-1:0]  msb_flip;
  logic          deq, dgt;

  digit_compare #(.D(D)) u_digit_compare (
    .x   (sa_q[W-1 -: D]),
    .y   (sb_q[W-1 -: D]),
    .deq (deq),
    .dgt (dgt)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    k_d      = k_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    msb_flip = '0;
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    msb_flip[W-1] = signed_mode;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a ^ msb_flip;
          sb_d    = b ^ msb_flip;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!deq) begin
          eq_d    = 1'b0;
          gt_d    = dgt;
          lt_d    = !dgt;
          state_d = DONE;
        end else if (k_q == KLAST) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          sa_d = sa_q << D;
          sb_d = sb_q << D;
          k_d  = k_q + KW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      k_q     <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      k_q     <= k_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: W=8/D=2 directed scenarios plus a W=8/D=8 random sweep.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, sm = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, eq, gt, lt;

  logic       start2 = 1'b0, sm2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic       busy2, done2, eq2, gt2, lt2;

  serial_magnitude_comparator #(.W(8), .D(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  serial_magnitude_comparator #(.W(8), .D(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .eq(eq2), .gt(gt2), .lt(lt2)
  );

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   n;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int passed = 0;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic s, input int d);
    exp_t r;
    logic [7:0] diff, t;
    r.eq = (x == y);
    if (s) begin
      r.gt = ($signed(x) > $signed(y));
      r.lt = ($signed(x) < $signed(y));
    end else begin
      r.gt = (x > y);
      r.lt = (x < y);
    end
    diff = x ^ y;
    r.n  = 8 / d;
    for (int i = 0; i < 8 / d; i++) begin
      t = diff << (d * i);
      if ((t >> (8 - d)) != 0) begin
        r.n = i + 1;
        break;
      end
    end
    return r;
  endfunction

  task automatic issue(input logic [7:0] xa, input logic [7:0] xb, input logic xs);
    a = xa; b = xb; sm = xs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue2(input logic [7:0] xa, input logic [7:0] xb, input logic xs);
    a2 = xa; b2 = xb; sm2 = xs; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  // Called just after the accepting edge; lat is cycles until done, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0)
      $display("FAIL reset_d2: got %b want 00000", {busy, done, eq, gt, lt});
    else passed++;
    checks++;
    if ({busy2, done2, eq2, gt2, lt2} !== 5'b0)
      $display("FAIL reset_d8: got %b want 00000", {busy2, done2, eq2, gt2, lt2});
    else passed++;
  endtask

  task automatic test_equal();
    int lat, bc;
    exp_t e;
    issue(8'hA5, 8'hA5, 1'b0);
    sb_q.push_back('{eq: 1'b1, gt: 1'b0, lt: 1'b0, n: 4});
    wait_done(lat, bc);
    e = sb_q.pop_front();
    checks++;
    if (lat !== e.n) $display("FAIL equal_latency: got %0d want %0d", lat, e.n);
    else passed++;
    checks++;
    if ({eq, gt, lt} !== {e.eq, e.gt, e.lt})
      $display("FAIL equal_result: got %b want %b", {eq, gt, lt}, {e.eq, e.gt, e.lt});
    else passed++;
    checks++;
    if (bc !== 4) $display("FAIL equal_busy_cycles: got %0d want 4", bc);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL equal_busy_in_done: got %b want 0", busy);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({done, eq} !== 2'b01) $display("FAIL equal_pulse_hold: got %b want 01", {done, eq});
    else passed++;
  endtask

  // Table of {a, b, signed, eq, gt, lt, N} directed cases.
  task automatic test_digits();
    logic [7:0] ta [6] = '{8'h80, 8'h80, 8'h3C, 8'hFF, 8'h12, 8'h7F};
    logic [7:0] tb [6] = '{8'h7F, 8'h7F, 8'h3D, 8'hFE, 8'h13, 8'h80};
    logic       ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] tr [6] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010};
    int         tn [6] = '{1, 1, 4, 4, 4, 1};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], ts[i]);
      sb_q.push_back('{eq: tr[i][2], gt: tr[i][1], lt: tr[i][0], n: tn[i]});
      wait_done(lat, bc);
      e = sb_q.pop_front();
      checks++;
      if (lat !== e.n) $display("FAIL digits%0d_latency: got %0d want %0d", i, lat, e.n);
      else passed++;
      checks++;
      if ({eq, gt, lt} !== {e.eq, e.gt, e.lt})
        $display("FAIL digits%0d_result: got %b want %b", i, {eq, gt, lt}, {e.eq, e.gt, e.lt});
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    exp_t e;
    issue(8'h12, 8'h34, 1'b0);
    sb_q.push_back('{eq: 1'b0, gt: 1'b0, lt: 1'b1, n: 2});
    // Hold start with different operands through RUN and DONE.
    a = 8'h99; b = 8'h11; start = 1'b1;
    wait_done(lat, bc);
    start = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (lat !== e.n) $display("FAIL ignore_latency: got %0d want %0d", lat, e.n);
    else passed++;
    checks++;
    if ({eq, gt, lt} !== {e.eq, e.gt, e.lt})
      $display("FAIL ignore_result: got %b want %b", {eq, gt, lt}, {e.eq, e.gt, e.lt});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) $display("FAIL ignore_idle%0d: got %b want 00", i, {busy, done});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    exp_t e;
    issue(8'hC0, 8'h40, 1'b0);
    sb_q.push_back('{eq: 1'b0, gt: 1'b1, lt: 1'b0, n: 1});
    wait_done(lat, bc);
    e = sb_q.pop_front();
    checks++;
    if ({lat, eq, gt, lt} !== {e.n, e.eq, e.gt, e.lt})
      $display("FAIL b2b_first: got lat=%0d %b want lat=%0d %b", lat, {eq, gt, lt}, e.n, {e.eq, e.gt, e.lt});
    else passed++;
    @(posedge clk); #1;
    issue(8'h40, 8'hC0, 1'b0);
    sb_q.push_back('{eq: 1'b0, gt: 1'b0, lt: 1'b1, n: 1});
    checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy);
    else passed++;
    wait_done(lat, bc);
    e = sb_q.pop_front();
    checks++;
    if ({lat, eq, gt, lt} !== {e.n, e.eq, e.gt, e.lt})
      $display("FAIL b2b_second: got lat=%0d %b want lat=%0d %b", lat, {eq, gt, lt}, e.n, {e.eq, e.gt, e.lt});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat, bc;
    int seen;
    exp_t e;
    issue(8'h55, 8'h55, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0)
      $display("FAIL midreset_clear: got %b want 00000", {busy, done, eq, gt, lt});
    else passed++;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
    else passed++;
    issue(8'h55, 8'h54, 1'b0);
    sb_q.push_back('{eq: 1'b0, gt: 1'b1, lt: 1'b0, n: 4});
    wait_done(lat, bc);
    e = sb_q.pop_front();
    checks++;
    if ({lat, eq, gt, lt} !== {e.n, e.eq, e.gt, e.lt})
      $display("FAIL midreset_next: got lat=%0d %b want lat=%0d %b", lat, {eq, gt, lt}, e.n, {e.eq, e.gt, e.lt});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_digit_sweep();
    logic [7:0] xa, xb;
    logic       xs;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      xa = 8'($urandom);
      xb = (i % 8 == 0) ? xa : 8'($urandom);
      xs = 1'($urandom_range(0, 1));
      issue2(xa, xb, xs);
      sb_q.push_back(model(xa, xb, xs, 8));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (done2 !== 1'b1 || e.n !== 1)
        $display("FAIL sweep%0d_latency: got done=%b want done=1 (n=%0d)", i, done2, e.n);
      else passed++;
      checks++;
      if ({eq2, gt2, lt2} !== {e.eq, e.gt, e.lt})
        $display("FAIL sweep%0d_result a=%h b=%h s=%b: got %b want %b",
                 i, xa, xb, xs, {eq2, gt2, lt2}, {e.eq, e.gt, e.lt});
      else passed++;
      checks++;
      if ((32'(eq2) + 32'(gt2) + 32'(lt2)) !== 1)
        $display("FAIL sweep%0d_onehot: got %b want exactly one set", i, {eq2, gt2, lt2});
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_equal();
    test_digits();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_full_digit_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
